// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
// Command FIFO feeding an external combinational ALU: issues one queued command at a time,
// captures the ALU result and holds it on a valid/ready result port until accepted.
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [3:0]       cmdOpcode,
  input  logic [WIDTH-1:0] cmdInput1,
  input  logic [WIDTH-1:0] cmdInput2,
  input  logic [4:0]       cmdShift,
  output logic [3:0]       aluOpcode,
  output logic [WIDTH-1:0] aluInput1,
  output logic [WIDTH-1:0] aluInput2,
  output logic [4:0]       aluShiftValue,
  input  logic [WIDTH-1:0] aluResult,
  input  logic             aluCarryFlag,
  input  logic             aluZeroFlag,
  input  logic             aluOverFlowFlag,
  output logic             resValid,
  input  logic             resReady,
  output logic [WIDTH-1:0] resData,
  output logic [2:0]       resFlags,
  output logic             resError,
  output logic [15:0]      opCount
);

  // state   | meaning
  // IDLE    | nothing to do, waiting for a queued (or arriving) command
  // ISSUE   | head entry loaded into the ALU drive registers, FIFO popped
  // CAPTURE | ALU output settled, registered into the result port
  // HOLD    | result presented, waiting for resReady
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 4 + 2 * WIDTH + 5;

  state_t state_q, state_d;

  logic [EW-1:0]    fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push, pop, fifo_empty, res_accept;
  logic [EW-1:0]    head;
  logic [3:0]       head_op;
  logic [WIDTH-1:0] head_a, head_b;
  logic [4:0]       head_sh;
  logic [15:0]      op_count_q;

  assign cmdReady   = (count_q != CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = cmdValid && cmdReady;
  assign pop        = (state_q == ISSUE);
  assign res_accept = (state_q == HOLD) && resReady;
  assign opCount    = op_count_q;

  assign head = fifo_mem[rd_ptr_q];
  assign {head_op, head_a, head_b, head_sh} = head;

  // Storage needs no reset: occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmdOpcode, cmdInput1, cmdInput2, cmdShift};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A push in the same cycle counts as non-empty so a lone command issues right away.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty || push) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = HOLD;
      HOLD:    if (resReady) state_d = (!fifo_empty || push) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluOpcode     <= '0;
      aluInput1     <= '0;
      aluInput2     <= '0;
      aluShiftValue <= '0;
    end else if (state_q == ISSUE) begin
      aluOpcode     <= head_op;
      aluInput1     <= head_a;
      aluInput2     <= head_b;
      aluShiftValue <= head_sh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resValid   <= 1'b0;
      resData    <= '0;
      resFlags   <= '0;
      resError   <= 1'b0;
      op_count_q <= '0;
    end else begin
      if (state_q == CAPTURE) begin
        resValid <= 1'b1;
        if (aluOpcode > 4'd5) begin
          resData  <= '0;
          resFlags <= '0;
          resError <= 1'b1;
        end else begin
          resData  <= aluResult;
          resFlags <= {aluCarryFlag, aluZeroFlag, aluOverFlowFlag};
          resError <= 1'b0;
        end
      end
      if (res_accept) begin
        resValid   <= 1'b0;
        op_count_q <= op_count_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for alu_cmd_sequencer: behavioural ALU on the alu* port, expected results
// queued at command acceptance and checked by an independent monitor on the result port.
module tb_alu_cmd_sequencer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk, rst_n;
  logic             cmdValid, cmdReady;
  logic [3:0]       cmdOpcode;
  logic [WIDTH-1:0] cmdInput1, cmdInput2;
  logic [4:0]       cmdShift;
  logic [3:0]       aluOpcode;
  logic [WIDTH-1:0] aluInput1, aluInput2;
  logic [4:0]       aluShiftValue;
  logic [WIDTH-1:0] aluResult;
  logic             aluCarryFlag, aluZeroFlag, aluOverFlowFlag;
  logic             resValid, resReady;
  logic [WIDTH-1:0] resData;
  logic [2:0]       resFlags;
  logic             resError;
  logic [15:0]      opCount;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOpcode(cmdOpcode),
    .cmdInput1(cmdInput1), .cmdInput2(cmdInput2), .cmdShift(cmdShift),
    .aluOpcode(aluOpcode), .aluInput1(aluInput1), .aluInput2(aluInput2),
    .aluShiftValue(aluShiftValue), .aluResult(aluResult),
    .aluCarryFlag(aluCarryFlag), .aluZeroFlag(aluZeroFlag), .aluOverFlowFlag(aluOverFlowFlag),
    .resValid(resValid), .resReady(resReady), .resData(resData), .resFlags(resFlags),
    .resError(resError), .opCount(opCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] flags;
    logic       err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_ops = 16'd0;
  bit          mon_en = 1'b0;

  // ALU behaviour: {result, carry, zero, overflow}; unknown opcodes return junk the DUT must mask.
  function automatic logic [10:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [4:0] sh);
    logic [8:0] wide;
    logic [7:0] r;
    logic       c, o;
    wide = '0; r = '0; c = 1'b0; o = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: r = (sh >= 5'd8) ? 8'h00 : 8'(a << sh);
      4'd4: begin
        wide = {1'b0, a} - {1'b0, b}; r = wide[7:0]; c = wide[8];
        o = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'd5: begin
        wide = {1'b0, a} + {1'b0, b}; r = wide[7:0]; c = wide[8];
        o = (a[7] == b[7]) && (r[7] != a[7]);
      end
      default: begin r = a ^ 8'hA5; c = 1'b1; o = 1'b1; end
    endcase
    return {r, c, (r == 8'h00), o};
  endfunction

  function automatic exp_t expect_of(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] b, input logic [4:0] sh);
    logic [10:0] v;
    exp_t e;
    if (op > 4'd5) begin
      e = '{data: 8'h00, flags: 3'b000, err: 1'b1};
    end else begin
      v = alu_f(op, a, b, sh);
      e = '{data: v[10:3], flags: v[2:0], err: 1'b0};
    end
    return e;
  endfunction

  logic [10:0] alu_bus;
  assign alu_bus = alu_f(aluOpcode, aluInput1, aluInput2, aluShiftValue);
  assign aluResult       = alu_bus[10:3];
  assign aluCarryFlag    = alu_bus[2];
  assign aluZeroFlag     = alu_bus[1];
  assign aluOverFlowFlag = alu_bus[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: opCount tracks accepted beats; any presented beat must equal the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("opcount", 32'(opCount), 32'(exp_ops));
      if (resValid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(resValid), 32'd0);
        end else begin
          chk("result", 32'({resData, resFlags, resError}), 32'(exp_q[0]));
          if (resReady) begin
            void'(exp_q.pop_front());
            exp_ops = exp_ops + 16'd1;
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns one edge later, again just after it.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [4:0] sh, output bit acc);
    cmdOpcode = op; cmdInput1 = a; cmdInput2 = b; cmdShift = sh; cmdValid = 1'b1;
    @(negedge clk);
    acc = cmdReady;
    if (acc) exp_q.push_back(expect_of(op, a, b, sh));
    @(posedge clk);
    #1 cmdValid = 1'b0;
  endtask

  task automatic send_wait(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [4:0] sh);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) send(op, a, b, sh, acc);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_rand(output bit acc);
    logic [3:0] op;
    op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
    send(op, 8'($urandom), 8'($urandom), 5'($urandom), acc);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = budget;
    while (exp_q.size() > 0 && n > 0) begin
      @(posedge clk);
      n--;
    end
    if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_res_valid(input string name);
    int n;
    n = 0;
    while (!resValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resValid) chk(name, 32'(resValid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_resvalid"}, 32'(resValid), 32'd0);
    chk({tag, "_resdata"},  32'(resData),  32'd0);
    chk({tag, "_resflags"}, 32'(resFlags), 32'd0);
    chk({tag, "_reserror"}, 32'(resError), 32'd0);
    chk({tag, "_opcount"},  32'(opCount),  32'd0);
    chk({tag, "_alu"}, 32'({aluOpcode, aluInput1, aluInput2, aluShiftValue}), 32'd0);
    chk({tag, "_cmdready"}, 32'(cmdReady), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int lat;
    rst_n = 1'b1; cmdValid = 1'b0; cmdOpcode = '0; cmdInput1 = '0; cmdInput2 = '0;
    cmdShift = '0; resReady = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_reset", 32'(cmdReady), 32'd1);

    // Single ADD 7F+01 from idle: overflow, result 2 edges after issue (3 after the push edge).
    resReady = 1'b1;
    send(4'd5, 8'h7F, 8'h01, 5'd0, acc);
    chk("single_acc", 32'(acc), 32'd1);
    lat = 1;
    @(negedge clk);
    while (!resValid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    chk("single_data", 32'(resData), 32'h80);
    chk("single_flags", 32'(resFlags), 32'b001);
    @(posedge clk);
    @(negedge clk) chk("single_opcount", 32'(opCount), 32'd1);
    wait_drain(20);

    // Backpressure: one in flight plus DEPTH queued fills the FIFO.
    resReady = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      send_rand(acc);
      chk("bp_acc", 32'(acc), 32'd1);
    end
    @(negedge clk) chk("bp_full", 32'(cmdReady), 32'd0);
    @(posedge clk);
    #1 send(4'd1, 8'h11, 8'h22, 5'd0, acc);
    chk("bp_reject", 32'(acc), 32'd0);
    repeat (6) @(posedge clk);
    #1 resReady = 1'b1;
    wait_drain(100);

    // Bad opcode is flagged and zeroed; the following good op is clean.
    send_wait(4'd9, 8'h5A, 8'h3C, 5'd2);
    @(negedge clk);
    wait_res_valid("bad_wait");
    chk("bad_error", 32'(resError), 32'd1);
    chk("bad_data", 32'(resData), 32'd0);
    chk("bad_flags", 32'(resFlags), 32'd0);
    @(posedge clk);
    #1 send_wait(4'd4, 8'h10, 8'h20, 5'd0);
    wait_drain(30);

    // Push/pop together at DEPTH-1 occupancy keeps the count, then one more push fills it.
    resReady = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_rand(acc);
    @(negedge clk);
    wait_res_valid("pp_wait");
    @(posedge clk);
    #1 resReady = 1'b1;
    @(posedge clk);
    #1 send(4'd2, 8'hF0, 8'h0F, 5'd0, acc);
    chk("pp_acc_issue", 32'(acc), 32'd1);
    send(4'd3, 8'h81, 8'h00, 5'd1, acc);
    chk("pp_acc_capture", 32'(acc), 32'd1);
    @(negedge clk) chk("pp_full_after", 32'(cmdReady), 32'd0);
    @(posedge clk);
    #1 wait_drain(100);

    // Reset while holding a result with three commands queued.
    resReady = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_rand(acc);
    @(negedge clk);
    wait_res_valid("rst_wait");
    @(posedge clk);
    #3 mon_en = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs("midhold");
    exp_q.delete();
    exp_ops = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1 resReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) chk("no_stale", 32'(resValid), 32'd0);
    end
    @(posedge clk);
    #1 send_wait(4'd0, 8'hCC, 8'hAA, 5'd0);
    wait_drain(30);

    // opCount wrap, preloaded near the top.
    @(negedge clk);
    mon_en = 1'b0;
    force dut.op_count_q = 16'hFFFE;
    exp_ops = 16'hFFFE;
    @(posedge clk);
    #1 release dut.op_count_q;
    mon_en = 1'b1;
    send_wait(4'd5, 8'hFF, 8'h01, 5'd0);
    send_wait(4'd1, 8'h00, 8'h00, 5'd0);
    wait_drain(40);
    chk("opcount_wrap", 32'(opCount), 32'd0);

    // Randomized traffic with random downstream stalls.
    for (int i = 0; i < 400; i++) begin
      resReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) send_rand(acc);
      else begin
        @(posedge clk);
        #1;
      end
    end
    resReady = 1'b1;
    wait_drain(200);
    chk("final_opcount", 32'(opCount), 32'(exp_ops));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
